// File: rtl/tone_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tone_generator: square-wave buzzer driver with pending-note handoff.     |
// | Optional VOLUME_PWM_EN gates the square with a 3-bit PWM volume level.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tone_generator #(
    parameter int CLK_FREQ      = 100000000,
    parameter int SIM_DIV_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] note_in,
    input  logic       note_valid,
    input  logic       enable,
    input  logic [2:0] volume,
    output logic       speaker,
    output logic       playing,
    output logic [9:0] cur_note
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        PENDING = 2'd2
    } state_t;

    // Middle-octave half periods in cycles at 100 MHz.
    localparam logic [19:0] c_hp_c = 20'd190839;
    localparam logic [19:0] c_hp_d = 20'd170068;
    localparam logic [19:0] c_hp_e = 20'd151515;
    localparam logic [19:0] c_hp_f = 20'd143266;
    localparam logic [19:0] c_hp_g = 20'd127551;
    localparam logic [19:0] c_hp_a = 20'd113636;
    localparam logic [19:0] c_hp_b = 20'd101214;
    localparam int          c_unused_clk_freq = CLK_FREQ;

    function automatic logic f_is_rest(input logic [9:0] note);
        logic [6:0] pitch;
        pitch = note[8:2];
        return (pitch == 7'd0) || ((pitch & (pitch - 7'd1)) != 7'd0);
    endfunction

    function automatic logic [19:0] f_half_period(input logic [9:0] note);
        logic [19:0] hp;
        hp = 20'd0;
        case (note[8:2])
            7'b0000001: hp = c_hp_c;
            7'b0000010: hp = c_hp_d;
            7'b0000100: hp = c_hp_e;
            7'b0001000: hp = c_hp_f;
            7'b0010000: hp = c_hp_g;
            7'b0100000: hp = c_hp_a;
            7'b1000000: hp = c_hp_b;
            default:    hp = 20'd0;
        endcase
        hp = hp >> SIM_DIV_SHIFT;
        case (note[1:0])
            2'b01:   hp = hp << 1;
            2'b10:   hp = hp >> 1;
            default: hp = hp;
        endcase
        // Sharp is applied after the octave shift.
        if (note[9]) begin
            hp = hp - (hp >> 4);
        end
        if (hp < 20'd2) begin
            hp = 20'd2;
        end
        return hp;
    endfunction

    state_t      r_state;
    logic        r_square;
    logic        r_playing;
    logic [9:0]  r_cur_note;
    logic [9:0]  r_pending;
    logic [19:0] r_counter;
    logic [19:0] r_half_period;

    logic w_run;
    logic w_at_toggle;
    logic w_note_changed;

    assign w_run          = enable & note_valid;
    assign w_at_toggle    = (r_counter == (r_half_period - 20'd1));
    assign w_note_changed = (note_in != r_cur_note);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_square      <= 1'b0;
            r_playing     <= 1'b0;
            r_cur_note    <= 10'd0;
            r_pending     <= 10'd0;
            r_counter     <= 20'd0;
            r_half_period <= 20'd2;
        end else begin
            case (r_state)
                IDLE: begin
                    r_square  <= 1'b0;
                    r_playing <= 1'b0;
                    r_counter <= 20'd0;
                    if (w_run && !f_is_rest(note_in)) begin
                        r_state       <= PLAY;
                        r_square      <= 1'b1;
                        r_playing     <= 1'b1;
                        r_cur_note    <= note_in;
                        r_half_period <= f_half_period(note_in);
                    end
                end
                PLAY: begin
                    // Losing enable or valid outranks a coincident toggle.
                    if (!w_run) begin
                        r_state   <= IDLE;
                        r_square  <= 1'b0;
                        r_playing <= 1'b0;
                        r_counter <= 20'd0;
                        r_pending <= 10'd0;
                    end else begin
                        if (w_at_toggle) begin
                            r_square  <= ~r_square;
                            r_counter <= 20'd0;
                        end else begin
                            r_counter <= r_counter + 20'd1;
                        end
                        if (w_note_changed) begin
                            r_pending <= note_in;
                            r_state   <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (!w_run) begin
                        r_state   <= IDLE;
                        r_square  <= 1'b0;
                        r_playing <= 1'b0;
                        r_counter <= 20'd0;
                        r_pending <= 10'd0;
                    end else if (w_at_toggle) begin
                        r_counter <= 20'd0;
                        if (f_is_rest(r_pending)) begin
                            r_state   <= IDLE;
                            r_square  <= 1'b0;
                            r_playing <= 1'b0;
                            r_pending <= 10'd0;
                        end else begin
                            r_state       <= PLAY;
                            r_square      <= ~r_square;
                            r_cur_note    <= r_pending;
                            r_half_period <= f_half_period(r_pending);
                        end
                    end else begin
                        r_counter <= r_counter + 20'd1;
                        if (w_note_changed) begin
                            r_pending <= note_in;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_square  <= 1'b0;
                    r_playing <= 1'b0;
                    r_counter <= 20'd0;
                end
            endcase
        end
    end

    assign playing  = r_playing;
    assign cur_note = r_cur_note;

`ifdef VOLUME_PWM_EN
    logic [2:0] r_pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= 3'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 3'd1;
        end
    end

    assign speaker = r_square & (r_pwm_cnt < volume);
`else
    logic w_unused_volume;
    assign w_unused_volume = ^volume;
    assign speaker         = r_square;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tone_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tone_generator: scoreboard bench; expected speaker events are queued  |
// | by the stimulus and consumed by an independent negedge monitor.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tone_generator;

    localparam int SHIFT = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] note_in = 10'd0;
    logic       note_valid = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] volume = 3'd0;
    logic       speaker;
    logic       playing;
    logic [9:0] cur_note;

    tone_generator #(
        .CLK_FREQ      (100000000),
        .SIM_DIV_SHIFT (SHIFT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .note_in    (note_in),
        .note_valid (note_valid),
        .enable     (enable),
        .volume     (volume),
        .speaker    (speaker),
        .playing    (playing),
        .cur_note   (cur_note)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_START = 0, EV_TOGGLE = 1, EV_STOP = 2} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        int         len;
        logic [9:0] note;
        bit         chk_note;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  now_t    = 0;
    int  base_hp[7] = '{190839, 170068, 151515, 143266, 127551, 113636, 101214};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0d, required %0d", name, act, req);
    endtask

    // Reference: table lookup, then octave, then sharp, then clamp.
    function automatic int model_hp(input logic [9:0] n);
        int idx;
        int hp;
        idx = 0;
        for (int i = 0; i < 7; i++) if (n[2+i]) idx = i;
        hp = base_hp[idx] / (1 << SHIFT);
        if (n[1:0] == 2'b01) hp = hp * 2;
        else if (n[1:0] == 2'b10) hp = hp / 2;
        if (n[9]) hp = hp - hp / 16;
        if (hp < 2) hp = 2;
        return hp;
    endfunction

    function automatic logic [9:0] rand_note();
        logic [6:0] p;
        p = 7'd1 << $urandom_range(0, 6);
        return {1'($urandom_range(0, 1)), p, 2'($urandom_range(0, 3))};
    endfunction

    function automatic logic [9:0] rand_rest();
        logic [6:0] p;
        do p = 7'($urandom); while ($countones(p) == 1);
        return {1'($urandom_range(0, 1)), p, 2'($urandom_range(0, 3))};
    endfunction

    function automatic void push_ev(input ev_kind_t k, input int len, input logic [9:0] n, input bit chk);
        ev_t e;
        e.kind = k; e.len = len; e.note = n; e.chk_note = chk;
        exp_q.push_back(e);
    endfunction

    task automatic handle(input ev_kind_t k, input int cnt);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: actual kind %0d, required none (cur_note %0d)", k, cur_note);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            case (k)
                EV_START: begin
                    check("start_speaker", speaker, 1);
                    check("start_note", cur_note, e.note);
                end
                EV_TOGGLE: begin
                    check("level_len", cnt, e.len);
                    check("toggle_note", cur_note, e.note);
                end
                default: begin
                    check("stop_speaker", speaker, 0);
                    if (e.chk_note) check("stop_note", cur_note, e.note);
                end
            endcase
        end
    endtask

    logic mon_sp = 1'b0;
    logic mon_pl = 1'b0;
    int   mon_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_sp  = speaker;
                mon_pl  = playing;
                mon_cnt = 0;
            end else begin
                mon_cnt++;
                if (playing && !mon_pl) begin
                    handle(EV_START, mon_cnt);
                    mon_cnt = 0;
                end else if (!playing && mon_pl) begin
                    handle(EV_STOP, mon_cnt);
                end else if (playing && (speaker !== mon_sp)) begin
                    handle(EV_TOGGLE, mon_cnt);
                    mon_cnt = 0;
                end
                mon_sp = speaker;
                mon_pl = playing;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait so that inputs set next are sampled at edge index target (entry edge = 0).
    task automatic goto_t(input int target);
        tick(target - 1 - now_t);
        now_t = target - 1;
    endtask

    task automatic start_tone(input logic [9:0] n);
        note_in    = n;
        enable     = 1'b1;
        note_valid = 1'b1;
        volume     = 3'($urandom);
        now_t      = -1;
    endtask

    task automatic drop(input bit use_en);
        if (use_en) enable = 1'b0;
        else note_valid = 1'b0;
    endtask

    task automatic run_steady(input logic [9:0] n, input int hp, input int nlev, input int k, input bit use_en);
        int ntog;
        ntog = (k == 0) ? nlev - 1 : nlev;
        push_ev(EV_START, 0, n, 1);
        for (int j = 0; j < ntog; j++) push_ev(EV_TOGGLE, hp, n, 1);
        push_ev(EV_STOP, 0, n, 1);
        start_tone(n);
        goto_t(nlev * hp + k);
        drop(use_en);
        tick(3);
    endtask

    task automatic run_change(input logic [9:0] x, input int hpx, input logic [9:0] y, input int hpy,
                              input bit y_rest, input bit two, input logic [9:0] z, input int hpz,
                              input int t, input int m, input int k_in, input bit use_en);
        int j_sw, s_edge, hpf, k, t2, ntog;
        bit two_ok, rest_f;
        logic [9:0] f;
        j_sw   = t / hpx + 1;
        s_edge = j_sw * hpx;
        two_ok = two && (s_edge - t >= 2);
        f      = two_ok ? z : y;
        hpf    = two_ok ? hpz : hpy;
        rest_f = !two_ok && y_rest;
        k      = (k_in >= 0) ? k_in : ((hpf > 1) ? $urandom_range(0, hpf - 1) : 0);
        push_ev(EV_START, 0, x, 1);
        for (int j = 1; j < j_sw; j++) push_ev(EV_TOGGLE, hpx, x, 1);
        if (rest_f) begin
            push_ev(EV_STOP, 0, x, 0);
        end else begin
            push_ev(EV_TOGGLE, hpx, f, 1);
            ntog = (k == 0) ? m - 1 : m;
            for (int j = 0; j < ntog; j++) push_ev(EV_TOGGLE, hpf, f, 1);
            push_ev(EV_STOP, 0, f, 1);
        end
        start_tone(x);
        goto_t(t);
        note_in = y;
        if (two_ok) begin
            t2 = $urandom_range(t + 1, s_edge - 1);
            goto_t(t2);
            note_in = z;
        end
        if (rest_f) begin
            goto_t(s_edge + 4);
            note_valid = 1'b0;
        end else begin
            goto_t(s_edge + m * hpf + k);
            drop(use_en);
        end
        tick(3);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, actual checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] n, x, y, z;
        int hp, kind;

        #12;
        check("reset_speaker", speaker, 0);
        check("reset_playing", playing, 0);
        check("reset_cur_note", cur_note, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        run_steady(10'b0000100000, 139, 4, 10, 0);
        run_change(10'b0010000000, 110, 10'b0000000110, 93, 0, 0, 10'd0, 0, 41, 3, 5, 0);
        run_steady(10'b1000000101, 349, 3, 20, 1);
        run_steady(10'b0000100000, 139, 4, 0, 0);

        enable = 1'b1; note_valid = 1'b1; note_in = 10'b0000000000;
        tick(5);
        check("rest0_playing", playing, 0);
        check("rest0_speaker", speaker, 0);
        note_in = 10'b0001100000;
        tick(5);
        check("rest2_playing", playing, 0);
        check("rest2_speaker", speaker, 0);
        note_valid = 1'b0;
        tick(2);

        for (int i = 0; i < 12; i++) begin
            n  = rand_note();
            hp = model_hp(n);
            run_steady(n, hp, $urandom_range(1, 4), $urandom_range(0, hp - 1), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 10; i++) begin
            x    = rand_note();
            kind = $urandom_range(0, 2);
            if (kind == 2) y = rand_rest();
            else do y = rand_note(); while (y == x);
            do z = rand_note(); while (z == x || z == y);
            run_change(x, model_hp(x), y, (kind == 2) ? 0 : model_hp(y), kind == 2, kind == 1,
                       z, model_hp(z), $urandom_range(1, 2 * model_hp(x)), $urandom_range(1, 3), -1,
                       1'($urandom_range(0, 1)));
        end

        // Asynchronous reset during a high level.
        n  = rand_note();
        hp = model_hp(n);
        push_ev(EV_START, 0, n, 1);
        push_ev(EV_TOGGLE, hp, n, 1);
        push_ev(EV_TOGGLE, hp, n, 1);
        start_tone(n);
        goto_t(2 * hp + hp / 2);
        #3;
        check("pre_reset_speaker", speaker, 1);
        rst_n = 1'b0;
        note_valid = 1'b0;
        #1;
        check("async_speaker", speaker, 0);
        check("async_playing", playing, 0);
        check("async_cur_note", cur_note, 0);
        check("queue_before_reset", exp_q.size(), 0);
        #20;
        tick(1);
        #3 rst_n = 1'b1;
        tick(2);
        check("post_reset_playing", playing, 0);
        check("post_reset_speaker", speaker, 0);

        tick(5);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tone_generator.md
TONE_GENERATOR -- requirements
Module: tone_generator

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, meaning system clock frequency in Hz (documentation only; the table in REQ-014 is fixed for 100 MHz).
REQ-002 SHALL have parameter SIM_DIV_SHIFT, default 0, meaning right-shift applied to every table half-period (use >0 only in simulation).
REQ-003 SHALL have ports: clk  input  1  system clock; rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: note_in  input  10  note word from the music memory stage (data_out); note_valid  input  1  note_in valid (output_ready).
REQ-005 SHALL have ports: enable  input  1  playback enable; volume  input  3  PWM volume level.
REQ-006 SHALL have ports: speaker  output  1  buzzer drive; playing  output  1  tone active; cur_note  output  10  note word currently sounding.

Function
REQ-007 SHALL decode note_in as: [8:2] one-hot pitch C,D,E,F,G,A,B (bit2=C ... bit8=B); [1:0] octave (00 middle, 01 low, 10 high, 11 middle); [9] sharp.
REQ-008 SHALL treat a word whose [8:2] field is not exactly one-hot as a rest.
REQ-009 SHALL implement states IDLE, PLAY and PENDING.
REQ-010 IDLE: speaker=0, playing=0; when enable=1, note_valid=1 and note_in is not a rest, SHALL enter PLAY on the next edge with speaker=1, counter=0, playing=1 and cur_note=note_in.
REQ-011 PLAY: counter SHALL increment each cycle; when counter==half_period-1 it SHALL toggle speaker and clear counter, so each level lasts exactly half_period cycles.
REQ-012 In PLAY, if note_in differs from cur_note, SHALL latch note_in into a pending register and enter PENDING; a later differing note SHALL overwrite pending, so only the latest note is applied.
REQ-013 PENDING: at the next toggle edge SHALL load pending into cur_note, recompute half_period, clear counter and return to PLAY; a pending rest SHALL go to IDLE at that edge with speaker=0.
REQ-014 Middle-octave half_period (cycles) SHALL be C 190839, D 170068, E 151515, F 143266, G 127551, A 113636, B 101214, each shifted right by SIM_DIV_SHIFT.
REQ-015 Low octave SHALL use half_period<<1 and high octave half_period>>1; sharp SHALL use hp-(hp>>4), applied after the octave shift; the counter and half_period SHALL be 20 bits wide.
REQ-016 From PLAY or PENDING, enable=0 or note_valid=0 SHALL force IDLE on the next edge: speaker=0, playing=0, counter=0, pending discarded, cur_note held.
REQ-017 If a drop of note_valid or enable coincides with a toggle edge, the drop SHALL win.
REQ-018 A half_period below 2 after shifting SHALL be clamped to 2.

Reset
REQ-019 rst_n=0 SHALL asynchronously set state=IDLE, speaker=0, playing=0, cur_note=0, counter=0, pending=0 and PWM counter=0.
REQ-020 Reset asserted mid-tone SHALL take effect without waiting for a clock edge.
REQ-021 Release of rst_n SHALL start from IDLE.

Configuration
REQ-022 With VOLUME_PWM_EN defined, a free-running 3-bit PWM counter SHALL gate the output: speaker = square AND (pwm_cnt < volume).
REQ-023 With VOLUME_PWM_EN defined, volume=0 SHALL give silence and volume=7 SHALL give 7/8 duty during high phases.
REQ-024 Without VOLUME_PWM_EN, speaker SHALL equal the raw square, volume SHALL be ignored, and no PWM counter SHALL exist.

Verification
REQ-025 SIM_DIV_SHIFT=10; enable=1, note_valid=1, note_in=0000100000 (F middle) -> PLAY next edge; speaker toggles every 139 cycles; playing=1; cur_note=0000100000.
REQ-026 While playing A middle (hp 110), switch note_in to C high (0000000110, hp 93) at counter=40 -> current level completes 110 cycles, then levels of 93 cycles; cur_note updates at that toggle.
REQ-027 Playing; drop note_valid on the same cycle as a toggle -> next edge speaker=0, playing=0, state IDLE.
REQ-028 note_in=0000000000 and then 0001100000 with note_valid=1 -> remains IDLE, speaker=0; sharp C low (1000000101): hp = 372 - 23 = 349.
REQ-029 Assert rst_n=0 mid high-phase, between clock edges -> speaker=0 and playing=0 immediately, cur_note=0.
REQ-030 With VOLUME_PWM_EN, volume=3 during a high phase -> speaker high 3 of every 8 cycles; volume=0 -> speaker constant 0.
